// File: rtl/regfile_reader_if.sv
// regfile_reader_if: request/response bus between a requester and the register-file read stage
interface regfile_reader_if #(
    parameter int WIDTH = 32,
    parameter int NREG  = 32
);
    localparam int AW = $clog2(NREG);

    logic [NREG*WIDTH-1:0] regs;
    logic                  req_valid;
    logic                  req_ready;
    logic [AW-1:0]         ra1;
    logic [AW-1:0]         ra2;
    logic                  we;
    logic [AW-1:0]         wa;
    logic [WIDTH-1:0]      wd;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [WIDTH-1:0]      rd1;
    logic [WIDTH-1:0]      rd2;

    modport master (
        output regs, req_valid, ra1, ra2, we, wa, wd, rsp_ready,
        input  req_ready, rsp_valid, rd1, rd2
    );

    modport slave (
        input  regs, req_valid, ra1, ra2, we, wa, wd, rsp_ready,
        output req_ready, rsp_valid, rd1, rd2
    );
endinterface

// File: rtl/regfile_reader.sv
// regfile_reader: two-port register read stage with write bypass and a one-entry response buffer
module regfile_reader #(
    parameter int WIDTH = 32,
    parameter int NREG  = 32
) (
    input  logic              clk,
    input  logic              reset,
    regfile_reader_if.slave   bus
);
    localparam int AW = $clog2(NREG);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_rd1, r_rd2, w_rd1_nxt, w_rd2_nxt;
    logic [AW-1:0]    r_a1, r_a2, w_a1_nxt, w_a2_nxt;
    logic             w_req_ready, w_accept, w_wr;

    // Address 0 and out-of-range addresses read zero; a same-cycle write wins over the bank contents
    function automatic logic [WIDTH-1:0] rd_port(input logic [AW-1:0] addr);
        if (addr == '0 || int'(addr) >= NREG) return '0;
        if (bus.we && bus.wa == addr) return bus.wd;
        return bus.regs[int'(addr)*WIDTH +: WIDTH];
    endfunction

    // Handshake, next state, and capture or refresh of the held response
    always_comb begin
        w_req_ready = (r_state == EMPTY) | bus.rsp_ready;
        w_accept    = bus.req_valid & w_req_ready;
        w_wr        = bus.we & (bus.wa != '0);
        w_state_nxt = r_state;
        w_rd1_nxt   = r_rd1;
        w_rd2_nxt   = r_rd2;
        w_a1_nxt    = r_a1;
        w_a2_nxt    = r_a2;
        if (w_accept) begin
            w_state_nxt = FULL;
            w_rd1_nxt   = rd_port(bus.ra1);
            w_rd2_nxt   = rd_port(bus.ra2);
            w_a1_nxt    = bus.ra1;
            w_a2_nxt    = bus.ra2;
        end else if (r_state == FULL) begin
            w_state_nxt = bus.rsp_ready ? EMPTY : FULL;
            w_rd1_nxt   = (w_wr && bus.wa == r_a1) ? bus.wd : r_rd1;
            w_rd2_nxt   = (w_wr && bus.wa == r_a2) ? bus.wd : r_rd2;
        end
    end

    // State and response registers, cleared immediately on reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= EMPTY;
            r_rd1   <= '0;
            r_rd2   <= '0;
            r_a1    <= '0;
            r_a2    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_rd1   <= w_rd1_nxt;
            r_rd2   <= w_rd2_nxt;
            r_a1    <= w_a1_nxt;
            r_a2    <= w_a2_nxt;
        end
    end

    assign bus.req_ready = w_req_ready;
    assign bus.rsp_valid = (r_state == FULL);
    assign bus.rd1       = r_rd1;
    assign bus.rd2       = r_rd2;
endmodule

// File: tb/tb_regfile_reader.sv
// tb_regfile_reader: directed vectors and stall/reset sequences for regfile_reader
module tb_regfile_reader;
    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    regfile_reader_if #(.WIDTH(32), .NREG(32)) bus ();

    regfile_reader #(.WIDTH(32), .NREG(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [31:0] e1;
        logic [31:0] e2;
    } vec_t;

    vec_t        tv[14];
    logic [31:0] rf[32];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rv, input logic [4:0] a1, input logic [4:0] a2,
                         input logic w, input logic [4:0] wadr, input logic [31:0] wdat,
                         input logic rr);
        bus.req_valid = rv;
        bus.ra1       = a1;
        bus.ra2       = a2;
        bus.we        = w;
        bus.wa        = wadr;
        bus.wd        = wdat;
        bus.rsp_ready = rr;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'h1000_0000 + i;
        rf[0] = 32'hFFFF_FFFF;
        rf[5] = 32'hDEAD_BEEF;
        rf[7] = 32'h1111_1111;
        rf[9] = 32'h1234_5678;
        for (int i = 0; i < 32; i++) bus.regs[i*32 +: 32] = rf[i];

        tv[0]  = '{5'd5,  5'd9, 1'b0, 5'd0,  32'h0,         32'hDEADBEEF, 32'h12345678};
        tv[1]  = '{5'd0,  5'd0, 1'b1, 5'd0,  32'hAAAAAAAA,  32'h00000000, 32'h00000000};
        tv[2]  = '{5'd7,  5'd0, 1'b1, 5'd7,  32'hCAFEF00D,  32'hCAFEF00D, 32'h00000000};
        tv[3]  = '{5'd3,  5'd3, 1'b0, 5'd0,  32'h0,         32'h10000003, 32'h10000003};
        tv[4]  = '{5'd31, 5'd7, 1'b1, 5'd31, 32'h5555AAAA,  32'h5555AAAA, 32'h11111111};
        tv[5]  = '{5'd2,  5'd4, 1'b1, 5'd6,  32'h99999999,  32'h10000002, 32'h10000004};
        tv[6]  = '{5'd1,  5'd8, 1'b0, 5'd0,  32'h0,         32'h10000001, 32'h10000008};
        tv[7]  = '{5'd2,  5'd7, 1'b0, 5'd0,  32'h0,         32'h10000002, 32'h11111111};
        tv[8]  = '{5'd3,  5'd6, 1'b0, 5'd0,  32'h0,         32'h10000003, 32'h10000006};
        tv[9]  = '{5'd4,  5'd5, 1'b0, 5'd0,  32'h0,         32'h10000004, 32'hDEADBEEF};
        tv[10] = '{5'd5,  5'd4, 1'b0, 5'd0,  32'h0,         32'hDEADBEEF, 32'h10000004};
        tv[11] = '{5'd6,  5'd3, 1'b0, 5'd0,  32'h0,         32'h10000006, 32'h10000003};
        tv[12] = '{5'd7,  5'd2, 1'b0, 5'd0,  32'h0,         32'h11111111, 32'h10000002};
        tv[13] = '{5'd8,  5'd1, 1'b0, 5'd0,  32'h0,         32'h10000008, 32'h10000001};

        reset = 1'b0;
        drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0);
        #2;
        chk("reset rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
        chk("reset rd1", bus.rd1, 32'h0);
        chk("reset rd2", bus.rd2, 32'h0);
        chk("reset req_ready", {31'b0, bus.req_ready}, 32'd1);
        #10;
        reset = 1'b1;

        // streaming table: one accept per cycle, response one edge later
        for (int k = 0; k < 14; k++) begin
            drive(1'b1, tv[k].ra1, tv[k].ra2, tv[k].we, tv[k].wa, tv[k].wd, 1'b1);
            #1;
            chk($sformatf("v%0d req_ready", k), {31'b0, bus.req_ready}, 32'd1);
            step();
            chk($sformatf("v%0d rsp_valid", k), {31'b0, bus.rsp_valid}, 32'd1);
            chk($sformatf("v%0d rd1", k), bus.rd1, tv[k].e1);
            chk($sformatf("v%0d rd2", k), bus.rd2, tv[k].e2);
        end
        drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1);
        step();
        chk("drain rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);

        // stall with coherence write, ignored request, write to r0, then one handshake
        drive(1'b1, 5'd1, 5'd3, 1'b0, 5'd0, 32'h0, 1'b0);
        step();
        chk("stall rsp_valid", {31'b0, bus.rsp_valid}, 32'd1);
        chk("stall rd2", bus.rd2, 32'h10000003);
        drive(1'b0, 5'd0, 5'd0, 1'b1, 5'd3, 32'h0000BEEF, 1'b0);
        #1;
        chk("stall req_ready", {31'b0, bus.req_ready}, 32'd0);
        step();
        chk("coh rd2", bus.rd2, 32'h0000BEEF);
        chk("coh rd1", bus.rd1, 32'h10000001);
        chk("coh rsp_valid", {31'b0, bus.rsp_valid}, 32'd1);
        chk("coh req_ready", {31'b0, bus.req_ready}, 32'd0);
        drive(1'b1, 5'd5, 5'd9, 1'b1, 5'd0, 32'hAAAAAAAA, 1'b0);
        step();
        chk("ignored rd1", bus.rd1, 32'h10000001);
        chk("ignored rd2", bus.rd2, 32'h0000BEEF);
        chk("ignored rsp_valid", {31'b0, bus.rsp_valid}, 32'd1);
        drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1);
        #1;
        chk("release req_ready", {31'b0, bus.req_ready}, 32'd1);
        step();
        chk("handshake empty", {31'b0, bus.rsp_valid}, 32'd0);
        step();
        chk("no second response", {31'b0, bus.rsp_valid}, 32'd0);

        // accept while FULL with a write to the departing address: bypass goes to the new request
        drive(1'b1, 5'd2, 5'd4, 1'b0, 5'd0, 32'h0, 1'b0);
        step();
        chk("b2b first rd2", bus.rd2, 32'h10000004);
        drive(1'b1, 5'd6, 5'd4, 1'b1, 5'd4, 32'h77777777, 1'b1);
        step();
        chk("b2b rsp_valid", {31'b0, bus.rsp_valid}, 32'd1);
        chk("b2b rd1", bus.rd1, 32'h10000006);
        chk("b2b bypass rd2", bus.rd2, 32'h77777777);
        drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1);
        step();
        chk("b2b drain", {31'b0, bus.rsp_valid}, 32'd0);

        // reset pulled mid-stall between edges
        drive(1'b1, 5'd5, 5'd9, 1'b0, 5'd0, 32'h0, 1'b0);
        step();
        chk("pre-reset rsp_valid", {31'b0, bus.rsp_valid}, 32'd1);
        drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        chk("async rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
        chk("async rd1", bus.rd1, 32'h0);
        chk("async rd2", bus.rd2, 32'h0);
        chk("async req_ready", {31'b0, bus.req_ready}, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        step();
        step();
        chk("no stale response", {31'b0, bus.rsp_valid}, 32'd0);
        chk("no stale rd1", bus.rd1, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/regfile_reader.md
REGFILE_READER -- requirements
Module: regfile_reader

Interface
REQ-001 Parameter WIDTH, default 32: data bits per register.
REQ-002 Parameter NREG, default 32: register count; address width AW = log2(NREG) = 5.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset: asserted when low, released synchronously to clk.
REQ-005 regs  input  NREG*WIDTH  flattened current contents of the bit-slice banks; register i occupies bits [i*WIDTH +: WIDTH].
REQ-006 req_valid  input  1  read request present.
REQ-007 req_ready  output  1  block can accept a request this cycle.
REQ-008 ra1, ra2  input  AW each  read addresses for ports 1 and 2.
REQ-009 we  input  1  same-cycle register-file write strobe, used for bypass.
REQ-010 wa  input  AW  write address; wd  input  WIDTH  write data.
REQ-011 rsp_valid  output  1  response data valid.
REQ-012 rsp_ready  input  1  downstream accepts the response.
REQ-013 rd1, rd2  output  WIDTH each  registered read data.

Function
REQ-014 Two states: EMPTY (no response held) and FULL (response held, rsp_valid=1).
REQ-015 req_ready = (state==EMPTY) | rsp_ready; purely combinational, no dependence on req_valid.
REQ-016 Accept when req_valid & req_ready; the response appears exactly 1 cycle later: rsp_valid=1, state FULL.
REQ-017 FULL & rsp_ready & no accept -> EMPTY, rsp_valid=0 next cycle. FULL & rsp_ready & accept -> stays FULL with the new data, giving back-to-back throughput of 1 per cycle.
REQ-018 FULL & !rsp_ready -> rd1/rd2/rsp_valid hold, except as required by REQ-021.
REQ-019 Captured data per port: address 0 -> all zeros; else if we & wa==addr & wa!=0 -> wd (bypass); else regs[addr].
REQ-020 Both ports are evaluated independently; ra1==ra2 is legal and returns identical data.
REQ-021 Held-data coherence: in FULL with no accept, a write (we, wa!=0) to the address held on a port replaces that port's rd with wd on the next edge. The block keeps both latched addresses (a1_q, a2_q) for this.
REQ-022 Write to address 0 never alters any output.
REQ-023 Accept and a same-cycle matching write: the bypass of REQ-019 applies to the new request; REQ-021 does not apply to the departing data.
REQ-024 req_valid while req_ready=0: request ignored, no state change; requester must hold.
REQ-025 Addresses >= NREG (only when NREG is not a power of 2) read zero.

Reset
REQ-026 reset low -> state EMPTY, rsp_valid=0, rd1=0, rd2=0, a1_q=0, a2_q=0 immediately, independent of clk.
REQ-027 req_ready=1 during and after reset. The first accept is possible on the first rising edge with reset high.
REQ-028 Reset asserted while FULL discards the held response; it is not re-presented after release.

Verification
REQ-029 regs[5]=0xDEADBEEF, regs[9]=0x12345678, ra1=5, ra2=9, req_valid=1, rsp_ready=1 -> next cycle rsp_valid=1, rd1=0xDEADBEEF, rd2=0x12345678.
REQ-030 ra1=0, ra2=0 with regs[0]=0xFFFFFFFF, plus we=1, wa=0, wd=0xAAAAAAAA -> rd1=rd2=0.
REQ-031 Request ra1=7 with we=1, wa=7, wd=0xCAFEF00D, regs[7]=0x11111111 -> rd1=0xCAFEF00D.
REQ-032 rsp_ready=0 after accepting ra2=3, then write we=1, wa=3, wd=0x0000BEEF -> next cycle rd2=0x0000BEEF, rsp_valid=1, req_ready=0; raise rsp_ready -> one handshake, then EMPTY.
REQ-033 rsp_ready=1 and req_valid=1 for 8 consecutive cycles with ra1 = 1..8 -> 8 consecutive rsp_valid cycles with rd1 = regs[1..8] in order, no bubbles.
REQ-034 Pull reset low mid-stall (FULL, rsp_ready=0) between clock edges -> rsp_valid, rd1 and rd2 go to 0 at once, req_ready=1; after release no stale response appears.
